// File: rtl/div_pkg.sv
// Shared widths, mode codes and FSM encoding for the divider request issuer.
// Combinational helpers only; no latency or flow control lives here.
package div_pkg;

   localparam int DIVIDEND_W = 32;
   localparam int DIVISOR_W  = 16;
   localparam int RESULT_W   = 32;

   localparam logic MODE_DIV = 1'b0;
   localparam logic MODE_MOD = 1'b1;

   localparam logic [RESULT_W-1:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   typedef struct packed {
      logic                  mode;
      logic [DIVISOR_W-1:0]  divisor;
      logic [DIVIDEND_W-1:0] dividend;
   } op_t;

   // A zero divisor yields all-ones for divide and leaves the dividend as the remainder.
   function automatic logic [RESULT_W-1:0] dz_result(input logic mode,
                                                     input logic [DIVIDEND_W-1:0] dividend);
      return (mode == MODE_MOD) ? dividend : DZ_QUOTIENT;
   endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous FIFO with combinational head read; 1-cycle write-to-read latency.
// Push is ignored when full unless popping in the same cycle; pop is ignored when empty.
module div_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_en;
   logic             pop_en;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign pop_en  = pop & ~empty;
   assign push_en = push & (~full | pop_en);
   assign rdata   = mem[rd_ptr];

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_en) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop_en) rd_ptr <= rd_ptr + PTR_ONE;
         if (push_en && !pop_en)      count <= count + CNT_ONE;
         else if (pop_en && !push_en) count <= count - CNT_ONE;
      end
   end

endmodule

// File: rtl/div_req_issuer.sv
// Queues tagged divide/modulo requests and issues them one at a time to the divider; issue 1 cycle after enqueue, response 1 cycle after result.
// req_ready drops when the FIFO is full; no op issues while the response slot is occupied and not draining.
module div_req_issuer
   import div_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_mode,
   input  logic [DIVISOR_W-1:0]  req_divisor,
   input  logic [DIVIDEND_W-1:0] req_dividend,
   input  logic [TAG_W-1:0]      req_tag,
   output logic                  div_valid_in,
   output logic                  div_mode,
   output logic [DIVISOR_W-1:0]  div_divisor,
   output logic [DIVIDEND_W-1:0] div_dividend,
   input  logic                  div_busy,
   input  logic                  div_valid_out,
   input  logic [RESULT_W-1:0]   div_result,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [RESULT_W-1:0]   rsp_result,
   output logic [TAG_W-1:0]      rsp_tag,
   output logic                  rsp_dz,
   output logic                  err_spurious
);

   localparam int FIFO_W = $bits(op_t) + TAG_W;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [FIFO_W-1:0] fifo_head;
   op_t               head_op;
   logic [TAG_W-1:0]  head_tag;
   op_t               req_op;

   state_t                state, state_n;
   logic                  div_valid_in_n;
   logic                  div_mode_n;
   logic [DIVISOR_W-1:0]  div_divisor_n;
   logic [DIVIDEND_W-1:0] div_dividend_n;
   logic [TAG_W-1:0]      issued_tag, issued_tag_n;
   logic                  rsp_valid_n;
   logic [RESULT_W-1:0]   rsp_result_n;
   logic [TAG_W-1:0]      rsp_tag_n;
   logic                  rsp_dz_n;
   logic                  err_spurious_n;
   logic                  slot_free;

   assign req_op.mode     = req_mode;
   assign req_op.divisor  = req_divisor;
   assign req_op.dividend = req_dividend;
   assign req_ready       = ~fifo_full;

   div_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (req_valid & req_ready),
      .wdata ({req_op, req_tag}),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_op   = fifo_head[FIFO_W-1:TAG_W];
   assign head_tag  = fifo_head[TAG_W-1:0];
   assign slot_free = ~rsp_valid | rsp_ready;

   always_comb begin
      state_n        = state;
      fifo_pop       = 1'b0;
      div_valid_in_n = 1'b0;
      div_mode_n     = div_mode;
      div_divisor_n  = div_divisor;
      div_dividend_n = div_dividend;
      issued_tag_n   = issued_tag;
      rsp_valid_n    = rsp_valid & ~rsp_ready;
      rsp_result_n   = rsp_result;
      rsp_tag_n      = rsp_tag;
      rsp_dz_n       = rsp_dz;
      err_spurious_n = err_spurious | (div_valid_out & (state != WAIT));

      case (state)
         IDLE: begin
            if (!fifo_empty && slot_free) begin
               if (head_op.divisor == '0) begin
                  fifo_pop     = 1'b1;
                  rsp_valid_n  = 1'b1;
                  rsp_result_n = dz_result(head_op.mode, head_op.dividend);
                  rsp_tag_n    = head_tag;
                  rsp_dz_n     = 1'b1;
               end else if (!div_busy) begin
                  fifo_pop       = 1'b1;
                  div_valid_in_n = 1'b1;
                  div_mode_n     = head_op.mode;
                  div_divisor_n  = head_op.divisor;
                  div_dividend_n = head_op.dividend;
                  issued_tag_n   = head_tag;
                  state_n        = ISSUE;
               end
            end
         end
         ISSUE: state_n = WAIT;
         WAIT: begin
            // The slot was free at issue time, so this load can never overwrite a pending response.
            if (div_valid_out) begin
               rsp_valid_n  = 1'b1;
               rsp_result_n = div_result;
               rsp_tag_n    = issued_tag;
               rsp_dz_n     = 1'b0;
               state_n      = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         div_valid_in <= 1'b0;
         div_mode     <= 1'b0;
         div_divisor  <= '0;
         div_dividend <= '0;
         issued_tag   <= '0;
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_tag      <= '0;
         rsp_dz       <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         state        <= state_n;
         div_valid_in <= div_valid_in_n;
         div_mode     <= div_mode_n;
         div_divisor  <= div_divisor_n;
         div_dividend <= div_dividend_n;
         issued_tag   <= issued_tag_n;
         rsp_valid    <= rsp_valid_n;
         rsp_result   <= rsp_result_n;
         rsp_tag      <= rsp_tag_n;
         rsp_dz       <= rsp_dz_n;
         err_spurious <= err_spurious_n;
      end
   end

endmodule

// File: tb/tb_div_req_issuer.sv
// Bench for div_req_issuer with a behavioural divider and a scoreboard of expected responses.
module tb_div_req_issuer;
   import div_pkg::*;

   localparam int FIFO_DEPTH = 4;
   localparam int TAG_W      = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_mode = 1'b0;
   logic [15:0]       req_divisor = '0;
   logic [31:0]       req_dividend = '0;
   logic [TAG_W-1:0]  req_tag = '0;
   logic              div_valid_in;
   logic              div_mode;
   logic [15:0]       div_divisor;
   logic [31:0]       div_dividend;
   logic              div_busy = 1'b0;
   logic              div_valid_out = 1'b0;
   logic [31:0]       div_result = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [31:0]       rsp_result;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_dz;
   logic              err_spurious;

   div_req_issuer #(.FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
      .req_divisor(req_divisor), .req_dividend(req_dividend), .req_tag(req_tag),
      .div_valid_in(div_valid_in), .div_mode(div_mode), .div_divisor(div_divisor),
      .div_dividend(div_dividend), .div_busy(div_busy), .div_valid_out(div_valid_out),
      .div_result(div_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_dz(rsp_dz),
      .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      result;
      logic [TAG_W-1:0] tag;
      logic             dz;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ops      = 0;
   int   nz       = 0;

   bit          m_busy = 0;
   int          m_cnt  = 0;
   logic        m_mode = 1'b0;
   logic [15:0] m_divisor = '0;
   logic [31:0] m_dividend = '0;
   int          max_lat = 6;
   bit          vout_legit_prev = 0;
   bit          slot_free_prev  = 1;
   bit          rsp_rand = 0;
   bit          rsp_hold = 0;
   bit          force_spur = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic rsp_t model(input logic mode, input logic [15:0] dvs,
                                  input logic [31:0] dvd, input logic [TAG_W-1:0] tag);
      rsp_t r;
      r.tag = tag;
      if (dvs == 16'd0) begin
         r.dz     = 1'b1;
         r.result = mode ? dvd : 32'hFFFF_FFFF;
      end else begin
         r.dz     = 1'b0;
         r.result = mode ? (dvd % {16'd0, dvs}) : (dvd / {16'd0, dvs});
      end
      return r;
   endfunction

   // Downstream divider, consumer and response monitor, all evaluated at the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         m_busy          = 0;
         m_cnt           = 0;
         div_valid_out   = 1'b0;
         div_busy        = 1'b0;
         vout_legit_prev = 0;
         slot_free_prev  = 1;
      end else begin
         if (vout_legit_prev) check("rsp_after_vout", rsp_valid, 1'b1);
         vout_legit_prev = 0;
         if (div_valid_in) begin
            check("issue_slot_free", slot_free_prev, 1'b1);
            check("issue_not_busy", m_busy, 1'b0);
            check("issue_divisor_nz", div_divisor != 16'd0, 1'b1);
            ops++;
            m_busy     = 1;
            m_cnt      = $urandom_range(max_lat, 2);
            m_mode     = div_mode;
            m_divisor  = div_divisor;
            m_dividend = div_dividend;
         end
         if (div_valid_out) begin
            div_valid_out = 1'b0;
         end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
               check("operands_stable", {div_mode, div_divisor, div_dividend},
                     {m_mode, m_divisor, m_dividend});
               if (m_divisor == 16'd0) div_result = '1;
               else div_result = m_mode ? m_dividend % {16'd0, m_divisor}
                                        : m_dividend / {16'd0, m_divisor};
               div_valid_out   = 1'b1;
               m_busy          = 0;
               vout_legit_prev = 1;
            end
         end else if (force_spur) begin
            div_result    = 32'hDEAD_BEEF;
            div_valid_out = 1'b1;
            force_spur    = 0;
         end
         div_busy = m_busy;

         if (rsp_hold)      rsp_ready = 1'b0;
         else if (rsp_rand) rsp_ready = ($urandom_range(3, 0) != 0);
         else               rsp_ready = 1'b1;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 1'b1, 1'b0);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               check("rsp_result", rsp_result, e.result);
               check("rsp_tag", rsp_tag, e.tag);
               check("rsp_dz", rsp_dz, e.dz);
            end
         end
         slot_free_prev = !rsp_valid || rsp_ready;
      end
   end

   task automatic push(input logic mode, input logic [15:0] dvs, input logic [31:0] dvd,
                       input logic [TAG_W-1:0] tag);
      int t = 0;
      req_valid    = 1'b1;
      req_mode     = mode;
      req_divisor  = dvs;
      req_dividend = dvd;
      req_tag      = tag;
      while (!req_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         check("req_ready_timeout", 1'b0, 1'b1);
         req_valid = 1'b0;
         return;
      end
      exp_q.push_back(model(mode, dvs, dvd, tag));
      if (dvs != 16'd0) nz++;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || m_busy || rsp_valid) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", t < 3000, 1'b1);
   endtask

   initial begin
      int o;
      int t;
      repeat (3) @(negedge clk);
      check("reset_outputs", {div_valid_in, div_mode, div_divisor, div_dividend, rsp_valid,
                              rsp_result, rsp_tag, rsp_dz, err_spurious}, '0);
      check("reset_req_ready", req_ready, 1'b1);
      #2 reset = 1'b0;
      @(negedge clk);

      // Single divide and issue latency
      push(MODE_DIV, 16'd5, 32'd17, 4'd3);
      @(negedge clk);
      check("issue_latency", div_valid_in, 1'b1);
      drain();
      check("one_issue", ops, 1);

      // Back-to-back, in order
      push(MODE_MOD, 16'd5, 32'd17, 4'd1);
      push(MODE_DIV, 16'd7, 32'd100, 4'd2);
      drain();
      check("two_issues", ops, 3);

      // Zero divisors bypass the divider
      o = ops;
      push(MODE_DIV, 16'd0, 32'd9, 4'd5);
      push(MODE_MOD, 16'd0, 32'd9, 4'd6);
      drain();
      check("dz_no_issue", ops, o);

      // Backpressure fills the FIFO
      o = ops;
      rsp_hold = 1;
      for (int i = 0; i < FIFO_DEPTH + 1; i++)
         push(i[0], 16'd3, 32'd100 + i, 4'(i));
      t = 0;
      while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      check("full_rsp_valid", rsp_valid, 1'b1);
      check("full_req_ready", req_ready, 1'b0);
      check("full_one_issue", ops, o + 1);
      rsp_hold = 0;
      push(MODE_MOD, 16'd7, 32'd50, 4'd15);
      drain();

      // Reset while waiting on the divider
      max_lat = 20;
      push(MODE_DIV, 16'd3, 32'd1000, 4'd7);
      t = 0;
      while (!m_busy && t < 100) begin @(negedge clk); t++; end
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midop_reset_outputs", {div_valid_in, div_mode, div_divisor, div_dividend, rsp_valid,
                                    rsp_result, rsp_tag, rsp_dz, err_spurious}, '0);
      check("midop_reset_req_ready", req_ready, 1'b1);
      exp_q.delete();
      @(negedge clk);
      #2 reset = 1'b0;
      max_lat = 6;
      @(negedge clk);
      push(MODE_DIV, 16'd2, 32'd8, 4'd9);
      drain();

      // Randomised traffic with random consumer stalls
      rsp_rand = 1;
      for (int i = 0; i < 40; i++) begin
         logic [15:0] dvs;
         int r;
         r = $urandom_range(9, 0);
         if (r < 2)      dvs = 16'd0;
         else if (r < 6) dvs = 16'($urandom_range(20, 1));
         else            dvs = 16'($urandom);
         push(1'($urandom_range(1, 0)), dvs, $urandom, 4'($urandom_range(15, 0)));
         repeat ($urandom_range(3, 0)) @(negedge clk);
      end
      drain();
      rsp_rand = 0;
      check("op_count", ops, nz);

      // Spurious result strobe while idle
      check("err_clear", err_spurious, 1'b0);
      force_spur = 1;
      repeat (3) @(negedge clk);
      check("err_set", err_spurious, 1'b1);
      check("spur_no_rsp", rsp_valid, 1'b0);
      repeat (5) @(negedge clk);
      check("err_sticky", err_spurious, 1'b1);
      check("spur_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
